dram_port_arbiter: RTL

Shares the single DRAM port (16-bit word address, 4-bit byte write enable, combinational read, synchronous write) between two masters. Master 0 is the core data port; master 1 is a secondary requester such as a program loader or debug/DMA engine. The block sits between the masters and the DRAM instance in the SoC top. It provides per-cycle grants, bounded hold (lock) support, and registered read return.

---
 rtl/dram_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/dram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : dram_port_arbiter                                              |
// | Brief   : Two-master arbiter for a single DRAM port: combinational grant,|
// |           bounded lock hold and registered read return. Define           |
// |           ARB_ROUND_ROBIN_EN for alternating contention, else m0 wins.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module dram_port_arbiter #(
    parameter int MEM_AW   = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              m0_req,
    input  logic              m0_lock,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req,
    input  logic              m1_lock,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic [MEM_AW-1:0] mem_a,
    output logic [3:0]        mem_we,
    output logic [31:0]       mem_d,
    input  logic [31:0]       mem_spo
);

    localparam logic [7:0] c_max_hold = 8'(MAX_HOLD);

    logic       r_owner;
    logic [7:0] r_hold_cnt;

    logic       w_own_req;
    logic       w_own_lock;
    logic       w_oth_req;
    logic       w_any_gnt;
    logic       w_sel;
    logic       w_contend_pick;
    logic [3:0] w_we_sel;
    logic       w_unused_addr;

    always_comb begin
        w_own_req  = r_owner ? m1_req  : m0_req;
        w_own_lock = r_owner ? m1_lock : m0_lock;
        w_oth_req  = r_owner ? m0_req  : m1_req;
        w_any_gnt  = m0_req | m1_req;
`ifdef ARB_ROUND_ROBIN_EN
        w_contend_pick = ~r_owner;
`else
        w_contend_pick = 1'b0;
`endif
        // Ordered rules: lock hold, expired hold with idle peer, contention, single.
        w_sel = m1_req;
        if (w_own_req && w_own_lock && (r_hold_cnt < c_max_hold)) begin
            w_sel = r_owner;
        end else if (w_own_req && !w_oth_req && (r_hold_cnt >= c_max_hold)) begin
            w_sel = r_owner;
        end else if (m0_req && m1_req) begin
            w_sel = w_contend_pick;
        end
    end

    assign m0_gnt   = w_any_gnt & ~w_sel;
    assign m1_gnt   = w_any_gnt &  w_sel;
    assign w_we_sel = w_sel ? m1_we : m0_we;
    assign mem_we   = w_any_gnt ? w_we_sel : 4'b0000;
    assign mem_a    = m1_gnt ? m1_addr[MEM_AW+1:2] : m0_addr[MEM_AW+1:2];
    assign mem_d    = w_sel ? m1_wdata : m0_wdata;

    // Byte offset and upper address bits never reach the word-addressed DRAM.
    assign w_unused_addr = ^{m0_addr, m1_addr};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner    <= 1'b1;
            r_hold_cnt <= 8'd0;
        end else if (!w_any_gnt) begin
            r_hold_cnt <= 8'd0;
        end else begin
            r_owner <= w_sel;
            if (w_sel != r_owner) begin
                r_hold_cnt <= 8'd1;
            end else if (w_oth_req && (r_hold_cnt != 8'hFF)) begin
                r_hold_cnt <= r_hold_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m0_rdata  <= 32'h0;
            m1_rdata  <= 32'h0;
        end else begin
            m0_rvalid <= m0_gnt && (m0_we == 4'b0000);
            m1_rvalid <= m1_gnt && (m1_we == 4'b0000);
            if (m0_gnt && (m0_we == 4'b0000)) begin
                m0_rdata <= mem_spo;
            end
            if (m1_gnt && (m1_we == 4'b0000)) begin
                m1_rdata <= mem_spo;
            end
        end
    end

endmodule
`default_nettype wire
